// File: rtl/cordic_sqrt_initiator.sv
// Synchronous initiator for the asynchronous CORDIC square-root unit: valid/ready in,
// four-phase START/FINISHED to the unit, valid/ready out with negative screening and timeout.
module cordic_sqrt_initiator #(
  parameter int FP32           = 31,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          ck,
  input  logic          arst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FP32:0] in_data,
  output logic          START,
  output logic [FP32:0] DATA_I,
  input  logic          FINISHED,
  input  logic [FP32:0] DATA_O,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [FP32:0] out_data,
  output logic          out_err
);

  localparam int W    = FP32 + 1;
  localparam int CMAX = (TIMEOUT_CYCLES > SYNC_STAGES) ? TIMEOUT_CYCLES : SYNC_STAGES + 1;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] CNT_TO   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SYNC = CW'(SYNC_STAGES);
  localparam logic [W-1:0]  QNAN     = W'(32'h7FC0_0000);
  localparam logic [W-1:0]  NEG_ZERO = {1'b1, {FP32{1'b0}}};

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_RELEASE,
    S_OUT
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                fin_s;
  logic                start_q, start_d;
  logic [W-1:0]        data_i_q, data_i_d;
  logic [W-1:0]        out_data_q, out_data_d;
  logic                out_err_q, out_err_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  always_ff @(posedge ck) begin
    if (arst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], FINISHED};
  end

  assign fin_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge ck) begin
    if (arst) begin
      state_q    <= S_DRAIN;
      start_q    <= 1'b0;
      data_i_q   <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      data_i_q   <= data_i_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    data_i_d   = data_i_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      // The synchroniser is cleared by reset, so let it refill before trusting fin_s=0.
      S_DRAIN: begin
        if (cnt_q < CNT_SYNC) cnt_d = cnt_q + 1'b1;
        else if (!fin_s)      state_d = S_IDLE;
      end
      S_IDLE: begin
        if (in_valid) begin
          if (in_data[FP32] && (in_data != NEG_ZERO)) begin
            out_data_d = QNAN;
            out_err_d  = 1'b1;
            state_d    = S_OUT;
          end else begin
            data_i_d = in_data;
            state_d  = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (fin_s) begin
          out_data_d = DATA_O;
          out_err_d  = 1'b0;
          start_d    = 1'b0;
          state_d    = S_RELEASE;
        end else if (cnt_q == CNT_TO) begin
          out_data_d = QNAN;
          out_err_d  = 1'b1;
          start_d    = 1'b0;
          state_d    = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!fin_s) state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_DRAIN;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign START     = start_q;
  assign DATA_I    = data_i_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule
